// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential 8/4 restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITERATIONS = 8;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, used only while the FSM runs.
module div_step
    import seq_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] p_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] p_out,
    output logic                 q_bit
);

    // The stored remainder is always below the divisor, so four bits hold it;
    // the shifted trial value needs the fifth bit.
    logic [DIVISOR_W:0] shifted;

    assign shifted = {p_in, dvd_bit};

    // Restore-or-subtract decision; the result always fits back in four bits.
    always_comb begin
        q_bit = 1'b0;
        p_out = shifted[DIVISOR_W-1:0];
        if (shifted >= {1'b0, divisor}) begin
            q_bit = 1'b1;
            p_out = DIVISOR_W'(shifted - {1'b0, divisor});
        end
    end

endmodule

// File: rtl/seq_div8x4.sv
// Sequential unsigned 8-bit by 4-bit restoring divider, one quotient bit per cycle.
// Latency: done pulses 9 cycles after an accepted start (1 cycle if divisor is 0).
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module seq_div8x4
    import seq_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] q,
    output logic [DIVISOR_W-1:0]  r,
    output logic                  div_zero
);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  last_iter;

    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after the last iteration this register holds the quotient.
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W-1:0]  p;
    logic [CNT_W-1:0]      cnt;

    logic [DIVISOR_W-1:0]  p_step;
    logic                  q_bit;

    assign accept    = start && (state != ST_RUN);
    assign last_iter = (cnt == CNT_W'(ITERATIONS - 1));
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    div_step u_step (
        .p_in    (p),
        .dvd_bit (dvd[DIVIDEND_W-1]),
        .divisor (dsr),
        .p_out   (p_step),
        .q_bit   (q_bit)
    );

    // Next-state selection; a zero divisor skips RUN entirely.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (b == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, operand capture, iteration datapath and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dvd      <= '0;
            dsr      <= '0;
            p        <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                dvd <= a;
                dsr <= b;
                p   <= '0;
                cnt <= '0;
                if (b == '0) begin
                    q        <= '1;
                    r        <= a[DIVISOR_W-1:0];
                    div_zero <= 1'b1;
                end
            end else if (state == ST_RUN) begin
                dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
                p   <= p_step;
                cnt <= cnt + 1'b1;
                // Outputs only change on the final iteration so no partial
                // quotient is ever visible.
                if (last_iter) begin
                    q        <= {dvd[DIVIDEND_W-2:0], q_bit};
                    r        <= p_step;
                    div_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div8x4.sv
// Directed self-checking bench for seq_div8x4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison goes through check_val.
module tb_seq_div8x4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [3:0] r;
    logic       div_zero;

    int n_chk  = 0;
    int n_pass = 0;

    localparam int BOUND = 30;

    seq_div8x4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one division, wait for done, check latency, busy time, results,
    // that q is frozen during RUN, and that done is a single-cycle pulse.
    task automatic run_div(input string tag, input logic [7:0] ta, input logic [3:0] tb,
                           input logic [7:0] eq, input logic [3:0] er, input logic edz,
                           input int elat);
        int         cyc;
        int         busy_cnt;
        logic [7:0] q0;
        logic       q_held;
        q0     = q;
        q_held = 1'b1;
        a      = ta;
        b      = tb;
        start  = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < BOUND) begin
            if (busy) busy_cnt++;
            if (q !== q0) q_held = 1'b0;
            step();
            cyc++;
        end
        check_val({tag, "_done_seen"}, done, 1);
        check_val({tag, "_latency"}, cyc, elat);
        check_val({tag, "_busy_cycles"}, busy_cnt, elat);
        check_val({tag, "_q_frozen_run"}, q_held, 1);
        check_val({tag, "_q"}, q, eq);
        check_val({tag, "_r"}, r, er);
        check_val({tag, "_div_zero"}, div_zero, edz);
        step();
        check_val({tag, "_done_pulse_end"}, done, 0);
        check_val({tag, "_q_hold"}, q, eq);
    endtask

    initial begin
        int e;
        int done_cnt;
        int e1;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'd0;
        b     = 4'd0;
        step();
        step();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_q", q, 0);
        check_val("rst_r", r, 0);
        check_val("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        step();

        run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
        run_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
        run_div("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
        run_div("d9_0", 8'd9, 4'd0, 8'hFF, 4'd9, 1'b1, 0);

        // Second start in the third RUN cycle must be ignored.
        a     = 8'd100;
        b     = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        e     = 0;
        step();
        step();
        e     = 2;
        check_val("ign_busy", busy, 1);
        a     = 8'd50;
        b     = 4'd7;
        start = 1'b1;
        step();
        e++;
        start = 1'b0;
        while (!done && e < BOUND) begin
            step();
            e++;
        end
        check_val("ign_latency", e, 8);
        check_val("ign_q", q, 33);
        check_val("ign_r", r, 1);
        check_val("ign_dz", div_zero, 0);
        step();

        // Reset in the fifth RUN cycle aborts with no done pulse.
        a     = 8'd200;
        b     = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_q", q, 0);
        check_val("abort_r", r, 0);
        check_val("abort_dz", div_zero, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) done_cnt++;
            step();
        end
        check_val("abort_no_done", done_cnt, 0);
        run_div("d64_8", 8'd64, 4'd8, 8'd8, 4'd0, 1'b0, 8);

        // Start held high through DONE: back-to-back operations.
        a     = 8'd17;
        b     = 4'd4;
        start = 1'b1;
        step();
        e = 0;
        while (!done && e < BOUND) begin
            step();
            e++;
        end
        e1 = e;
        check_val("b2b_first_lat", e1, 8);
        check_val("b2b_first_q", q, 4);
        check_val("b2b_first_r", r, 1);
        a = 8'd30;
        b = 4'd5;
        step();
        e++;
        check_val("b2b_restart_busy", busy, 1);
        while (!done && e < 2 * BOUND) begin
            step();
            e++;
        end
        start = 1'b0;
        check_val("b2b_gap", e - e1, 9);
        check_val("b2b_second_q", q, 6);
        check_val("b2b_second_r", r, 0);
        check_val("b2b_second_dz", div_zero, 0);
        step();
        check_val("b2b_idle_done", done, 0);
        check_val("b2b_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
